// File: rtl/btb_pkg.sv
// btb_pkg: shared BTB entry layout and saturating direction-counter helpers
package btb_pkg;

    localparam int CTR_MAXW = 8;

    typedef logic [CTR_MAXW-1:0] ctr_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        ctr_t        ctr;
    } btb_entry_t;

    function automatic ctr_t ctr_max(input int bits);
        return ctr_t'((1 << bits) - 1);
    endfunction

    function automatic ctr_t ctr_weak(input int bits);
        return ctr_t'(1 << (bits - 1));
    endfunction

    function automatic ctr_t ctr_step(input ctr_t c, input logic up, input int bits);
        return up ? ((c == ctr_max(bits)) ? c : c + 1'b1) : ((c == '0) ? c : c - 1'b1);
    endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// btb_victim_sel: choose allocation way (lowest invalid, else round-robin pointer)
module btb_victim_sel
    import btb_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int PW   = 1
) (
    input  logic [WAYS-1:0] valid,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   way,
    output logic            evict
);

    // scan downward so the lowest-numbered invalid way is the final pick
    always_comb begin
        way   = ptr;
        evict = 1'b1;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                way   = PW'(i);
                evict = 1'b0;
            end
        end
    end

endmodule

// File: rtl/btb_setassoc.sv
// btb_setassoc: set-associative branch target buffer with direction counters and stats
module btb_setassoc
    import btb_pkg::*;
#(
    parameter int SET_BITS = 4,
    parameter int WAYS     = 2,
    parameter int CTR_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    output logic        PredF,
    output logic [31:0] NPC_PredF,
    input  logic [31:0] PCE,
    input  logic        UpdE,
    input  logic        BranchE,
    input  logic        PredE,
    input  logic [31:0] NPC_PredE,
    input  logic [31:0] BrNPC,
    input  logic        FlushBTB,
    output logic [31:0] CntBranch,
    output logic [31:0] CntMispred
);

    localparam int   SETS     = 1 << SET_BITS;
    localparam int   PW       = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int   TSH      = SET_BITS + 2;
    localparam ctr_t CTR_WEAK = ctr_weak(CTR_BITS);

    btb_entry_t ent [SETS][WAYS];

    logic [SET_BITS-1:0] set_f, set_e;
    logic [31:0]         tag_f, tag_e;
    logic                hit_f, hit_e, evict, mispred;
    logic [PW-1:0]       way_f, way_e, alloc_way, ptr_cur;
    logic [WAYS-1:0]     valid_e;

    assign set_f = SET_BITS'(PCF >> 2);
    assign set_e = SET_BITS'(PCE >> 2);
    assign tag_f = PCF >> TSH;
    assign tag_e = PCE >> TSH;

    // tag match for fetch lookup and execute update; lowest matching way wins
    always_comb begin
        hit_f   = 1'b0;
        way_f   = '0;
        hit_e   = 1'b0;
        way_e   = '0;
        valid_e = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            valid_e[i] = ent[set_e][i].valid;
            if (ent[set_f][i].valid && ent[set_f][i].tag == tag_f) begin
                hit_f = 1'b1;
                way_f = PW'(i);
            end
            if (ent[set_e][i].valid && ent[set_e][i].tag == tag_e) begin
                hit_e = 1'b1;
                way_e = PW'(i);
            end
        end
    end

    assign PredF     = hit_f & ent[set_f][way_f].ctr[CTR_BITS-1];
    assign NPC_PredF = PredF ? ent[set_f][way_f].target : PCF + 32'd4;
    assign mispred   = (PredE != BranchE) | (PredE & BranchE & (NPC_PredE != BrNPC));

    btb_victim_sel #(.WAYS(WAYS), .PW(PW)) u_victim_sel (
        .valid (valid_e),
        .ptr   (ptr_cur),
        .way   (alloc_way),
        .evict (evict)
    );

    // entry array: flush beats update; hits train, taken misses allocate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    ent[s][w] <= '0;
        end else if (FlushBTB) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    ent[s][w].valid <= 1'b0;
        end else if (UpdE && hit_e) begin
            ent[set_e][way_e].ctr <= ctr_step(ent[set_e][way_e].ctr, BranchE, CTR_BITS);
            if (BranchE)
                ent[set_e][way_e].target <= BrNPC;
        end else if (UpdE && BranchE) begin
            ent[set_e][alloc_way] <= '{valid: 1'b1, tag: tag_e, target: BrNPC, ctr: CTR_WEAK};
        end
    end

    if (WAYS > 1) begin : g_ptr
        logic [PW-1:0] ptr [SETS];
        assign ptr_cur = ptr[set_e];
        // round-robin pointer moves only when an allocation displaced a valid entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst || FlushBTB) begin
                for (int s = 0; s < SETS; s++)
                    ptr[s] <= '0;
            end else if (UpdE && BranchE && !hit_e && evict) begin
                ptr[set_e] <= ptr[set_e] + 1'b1;
            end
        end
    end else begin : g_no_ptr
        assign ptr_cur = '0;
    end

    // statistics count every qualified update, flush or not
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CntBranch  <= '0;
            CntMispred <= '0;
        end else if (UpdE) begin
            CntBranch  <= CntBranch + 32'd1;
            CntMispred <= CntMispred + {31'd0, mispred};
        end
    end

endmodule

// File: tb/tb_btb_setassoc.sv
// tb_btb_setassoc: directed and randomized checks against a behavioural BTB model
module tb_btb_setassoc;
  localparam int NS = 16;
  localparam int NW = 2;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, NPC_PredF, PCE, NPC_PredE, BrNPC, CntBranch, CntMispred;
  logic        PredF, UpdE, BranchE, PredE, FlushBTB;
  int errors = 0;
  int checks = 0;
  bit          mv   [NS][NW];
  int unsigned mtag [NS][NW];
  int unsigned mtgt [NS][NW];
  int          mctr [NS][NW];
  int          mptr [NS];
  int unsigned m_br, m_mis;
  always #5 clk = ~clk;
  btb_setassoc #(.SET_BITS(4), .WAYS(NW), .CTR_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCF        (PCF),
    .PredF      (PredF),
    .NPC_PredF  (NPC_PredF),
    .PCE        (PCE),
    .UpdE       (UpdE),
    .BranchE    (BranchE),
    .PredE      (PredE),
    .NPC_PredE  (NPC_PredE),
    .BrNPC      (BrNPC),
    .FlushBTB   (FlushBTB),
    .CntBranch  (CntBranch),
    .CntMispred (CntMispred)
  );
  function automatic int m_set(input logic [31:0] pc);
    return int'((pc / 4) % NS);
  endfunction
  function automatic int m_way(input logic [31:0] pc);
    int s = m_set(pc);
    for (int w = 0; w < NW; w++)
      if (mv[s][w] && mtag[s][w] == pc / (NS * 4)) return w;
    return -1;
  endfunction
  function automatic logic m_pred(input logic [31:0] pc);
    int w = m_way(pc);
    return (w >= 0) && (mctr[m_set(pc)][w] >= 2);
  endfunction
  function automatic logic [31:0] m_npc(input logic [31:0] pc);
    return m_pred(pc) ? mtgt[m_set(pc)][m_way(pc)] : pc + 32'd4;
  endfunction
  function automatic void m_reset();
    for (int s = 0; s < NS; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        mv[s][w] = 0; mtag[s][w] = 0; mtgt[s][w] = 0; mctr[s][w] = 0;
      end
    end
    m_br = 0;
    m_mis = 0;
  endfunction
  function automatic void m_edge();
    int s = m_set(PCE);
    int w = m_way(PCE);
    int v = -1;
    if (UpdE) begin
      m_br++;
      if (PredE != BranchE || (PredE && BranchE && NPC_PredE != BrNPC)) m_mis++;
    end
    if (FlushBTB) begin
      for (int i = 0; i < NS; i++) begin
        mptr[i] = 0;
        for (int j = 0; j < NW; j++) mv[i][j] = 0;
      end
    end else if (UpdE && w >= 0) begin
      mctr[s][w] = BranchE ? ((mctr[s][w] < 3) ? mctr[s][w] + 1 : 3) : ((mctr[s][w] > 0) ? mctr[s][w] - 1 : 0);
      if (BranchE) mtgt[s][w] = BrNPC;
    end else if (UpdE && BranchE) begin
      for (int j = NW - 1; j >= 0; j--) if (!mv[s][j]) v = j;
      if (v < 0) begin
        v = mptr[s];
        mptr[s] = (mptr[s] + 1) % NW;
      end
      mv[s][v] = 1; mtag[s][v] = PCE / (NS * 4); mtgt[s][v] = BrNPC; mctr[s][v] = 2;
    end
  endfunction
  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    UpdE = 0;
    FlushBTB = 0;
  endtask
  task automatic upd(input logic [31:0] pc, input logic br, input logic pe,
                     input logic [31:0] npe, input logic [31:0] bn);
    PCE = pc; BranchE = br; PredE = pe; NPC_PredE = npe; BrNPC = bn; UpdE = 1;
    step();
  endtask
  task automatic test_reset();
    rst = 1; UpdE = 0; FlushBTB = 0; PCE = 0; BranchE = 0; PredE = 0; NPC_PredE = 0; BrNPC = 0;
    PCF = 32'h100;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (PredF !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b expected 0", PredF); end
    checks++; if (NPC_PredF !== 32'h104) begin errors++; $display("FAIL reset_npc: got %h expected 00000104", NPC_PredF); end
    checks++; if (CntBranch !== 32'd0) begin errors++; $display("FAIL reset_cntbranch: got %0d expected 0", CntBranch); end
    checks++; if (CntMispred !== 32'd0) begin errors++; $display("FAIL reset_cntmispred: got %0d expected 0", CntMispred); end
    PCE = 32'h24; BranchE = 1; PredE = 1; NPC_PredE = 32'h80; BrNPC = 32'h80; UpdE = 1;
    @(negedge clk);
    rst = 0;
    step();
    PCF = 32'h24; #1;
    checks++; if (PredF !== 1'b1) begin errors++; $display("FAIL release_update_pred: got %b expected 1", PredF); end
    checks++; if (NPC_PredF !== 32'h80) begin errors++; $display("FAIL release_update_npc: got %h expected 00000080", NPC_PredF); end
    checks++; if (CntBranch !== 32'd1) begin errors++; $display("FAIL release_update_cnt: got %0d expected 1", CntBranch); end
  endtask
  task automatic test_alloc();
    upd(32'h100, 1, 0, 32'h104, 32'h200);
    PCF = 32'h100; #1;
    checks++; if (PredF !== 1'b1) begin errors++; $display("FAIL alloc_pred: got %b expected 1", PredF); end
    checks++; if (NPC_PredF !== 32'h200) begin errors++; $display("FAIL alloc_npc: got %h expected 00000200", NPC_PredF); end
    checks++; if (CntMispred !== 32'd1) begin errors++; $display("FAIL alloc_mispred: got %0d expected 1", CntMispred); end
  endtask
  task automatic test_not_taken();
    upd(32'h100, 0, 1, 32'h200, 32'h104);
    PCF = 32'h100; #1;
    checks++; if (PredF !== 1'b0) begin errors++; $display("FAIL nt1_pred: got %b expected 0", PredF); end
    checks++; if (NPC_PredF !== 32'h104) begin errors++; $display("FAIL nt1_npc: got %h expected 00000104", NPC_PredF); end
    upd(32'h100, 0, 0, 32'h104, 32'h104);
    upd(32'h100, 1, 0, 32'h104, 32'h200);
    #1;
    checks++; if (PredF !== 1'b0) begin errors++; $display("FAIL nt_saturate_pred: got %b expected 0", PredF); end
    upd(32'h100, 1, 0, 32'h104, 32'h200);
    #1;
    checks++; if (PredF !== 1'b1) begin errors++; $display("FAIL nt_retrain_pred: got %b expected 1", PredF); end
    checks++; if (CntMispred !== m_mis) begin errors++; $display("FAIL nt_mispred: got %0d expected %0d", CntMispred, m_mis); end
  endtask
  task automatic test_eviction();
    FlushBTB = 1;
    step();
    PCF = 32'h100; #1;
    checks++; if (PredF !== 1'b0) begin errors++; $display("FAIL flush_clean_pred: got %b expected 0", PredF); end
    upd(32'h100, 1, 0, 32'h104, 32'h300);
    upd(32'h140, 1, 0, 32'h144, 32'h400);
    upd(32'h180, 1, 0, 32'h184, 32'h500);
    PCF = 32'h140; #1;
    checks++; if (NPC_PredF !== 32'h400 || PredF !== 1'b1) begin errors++; $display("FAIL evict_140: got %b/%h expected 1/00000400", PredF, NPC_PredF); end
    PCF = 32'h180; #1;
    checks++; if (NPC_PredF !== 32'h500 || PredF !== 1'b1) begin errors++; $display("FAIL evict_180: got %b/%h expected 1/00000500", PredF, NPC_PredF); end
    PCF = 32'h100; #1;
    checks++; if (NPC_PredF !== 32'h104 || PredF !== 1'b0) begin errors++; $display("FAIL evict_100: got %b/%h expected 0/00000104", PredF, NPC_PredF); end
  endtask
  task automatic test_target_mispred();
    int unsigned base;
    upd(32'h100, 1, 0, 32'h104, 32'h300);
    base = m_mis;
    upd(32'h100, 1, 1, 32'h300, 32'h200);
    PCF = 32'h100; #1;
    checks++; if (CntMispred !== base + 1) begin errors++; $display("FAIL target_mispred_cnt: got %0d expected %0d", CntMispred, base + 1); end
    checks++; if (NPC_PredF !== 32'h200 || PredF !== 1'b1) begin errors++; $display("FAIL target_update: got %b/%h expected 1/00000200", PredF, NPC_PredF); end
    PCF = 32'h140; #1;
    checks++; if (PredF !== 1'b0) begin errors++; $display("FAIL realloc_evicts_140: got %b expected 0", PredF); end
  endtask
  task automatic test_flush();
    int unsigned br0 = m_br;
    logic [31:0] pcs [4] = '{32'h140, 32'h100, 32'h180, 32'h24};
    FlushBTB = 1;
    upd(32'h140, 1, 0, 32'h144, 32'h600);
    for (int i = 0; i < 4; i++) begin
      PCF = pcs[i]; #1;
      checks++; if (PredF !== 1'b0 || NPC_PredF !== pcs[i] + 4) begin errors++; $display("FAIL flush_miss_%h: got %b/%h expected 0/%h", pcs[i], PredF, NPC_PredF, pcs[i] + 4); end
    end
    checks++; if (CntBranch !== br0 + 1) begin errors++; $display("FAIL flush_cntbranch: got %0d expected %0d", CntBranch, br0 + 1); end
  endtask
  task automatic test_random();
    logic [31:0] pc;
    for (int n = 0; n < 400; n++) begin
      PCF = (($urandom % 6) << 6) | (($urandom % 4) << 2) | ($urandom % 4);
      #1;
      checks++; if (PredF !== m_pred(PCF) || NPC_PredF !== m_npc(PCF)) begin errors++; $display("FAIL rand_lookup %0d pc=%h: got %b/%h expected %b/%h", n, PCF, PredF, NPC_PredF, m_pred(PCF), m_npc(PCF)); end
      pc = (($urandom % 6) << 6) | (($urandom % 4) << 2);
      PCE = pc;
      BranchE = 1'($urandom % 2);
      PredE = ($urandom % 5 == 0) ? ~m_pred(pc) : m_pred(pc);
      NPC_PredE = ($urandom % 6 == 0) ? 32'h900 : m_npc(pc);
      BrNPC = 32'h1000 + (($urandom % 4) << 4);
      UpdE = ($urandom % 4) != 0;
      FlushBTB = ($urandom % 40) == 0;
      step();
      checks++; if (CntBranch !== m_br || CntMispred !== m_mis) begin errors++; $display("FAIL rand_counters %0d: got %0d/%0d expected %0d/%0d", n, CntBranch, CntMispred, m_br, m_mis); end
    end
  endtask
  task automatic test_async_reset();
    upd(32'h100, 1, 0, 32'h104, 32'h700);
    PCF = 32'h100;
    #2 rst = 1;
    #1;
    m_reset();
    checks++; if (CntBranch !== 32'd0 || CntMispred !== 32'd0) begin errors++; $display("FAIL async_reset_cnt: got %0d/%0d expected 0/0", CntBranch, CntMispred); end
    checks++; if (PredF !== 1'b0 || NPC_PredF !== 32'h104) begin errors++; $display("FAIL async_reset_lookup: got %b/%h expected 0/00000104", PredF, NPC_PredF); end
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    test_reset();
    test_alloc();
    test_not_taken();
    test_eviction();
    test_target_mispred();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
